// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI-fed burst RAM: command encoding and read-pipeline FSM states.
package spi_ram_pkg;

    typedef enum logic [1:0] {
        SET_WADDR = 2'b00,
        WRITE     = 2'b01,
        SET_RADDR = 2'b10,
        READ      = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RD_MEM = 2'b01,
        RD_OUT = 2'b10
    } state_t;

endpackage

// File: rtl/spi_ram_mem.sv
// Storage for spi_ram_burst: one write port and one registered (synchronous) read port.
// A read and a write to the same address on the same edge return the old contents.
module spi_ram_mem
    import spi_ram_pkg::*;
#(
    parameter int MEM_WIDTH = 8,
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [MEM_WIDTH-1:0] wdata,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [MEM_WIDTH-1:0] rdata
);

    logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/spi_ram_burst.sv
// Command-driven RAM with a 2-cycle pipelined read path behind an SPI slave front end.
// Define SPI_RAM_AUTOINC_EN to make WRITE/READ post-increment their pointers (with wrap pulse).
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int MEM_WIDTH = 8,
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MEM_WIDTH+1:0] din,
    input  logic                 rx_valid,
    output logic [MEM_WIDTH-1:0] dout,
    output logic                 tx_valid,
    output logic                 addr_wrap
);

`ifdef SPI_RAM_AUTOINC_EN
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);
`endif

    cmd_t                 cmd;
    logic [MEM_WIDTH-1:0] payload;
    logic [ADDR_SIZE-1:0] set_addr;
    logic [ADDR_SIZE-1:0] waddr;
    logic [ADDR_SIZE-1:0] raddr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 wr_en;
    logic                 rd_cmd;
    logic                 rd_pend;
    logic                 mem_valid;
    logic [MEM_WIDTH-1:0] rdata;
    state_t               state;

    assign cmd      = cmd_t'(din[MEM_WIDTH+1:MEM_WIDTH]);
    assign payload  = din[MEM_WIDTH-1:0];
    assign wr_en    = rx_valid && (cmd == WRITE);
    assign rd_cmd   = rx_valid && (cmd == READ);
    assign set_addr = ADDR_SIZE'(32'(payload[ADDR_SIZE-1:0]) % MEM_DEPTH);

    spi_ram_mem #(
        .MEM_WIDTH(MEM_WIDTH),
        .ADDR_SIZE(ADDR_SIZE),
        .MEM_DEPTH(MEM_DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (wr_en),
        .waddr(waddr),
        .wdata(payload),
        .re   (rd_pend),
        .raddr(rd_addr),
        .rdata(rdata)
    );

    // Read path: latch address, RAM read, output register -- a valid bit travels with each read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr     <= '0;
            raddr     <= '0;
            rd_addr   <= '0;
            rd_pend   <= 1'b0;
            mem_valid <= 1'b0;
            tx_valid  <= 1'b0;
            dout      <= '0;
            addr_wrap <= 1'b0;
        end else begin
            addr_wrap <= 1'b0;
            rd_pend   <= rd_cmd;
            mem_valid <= rd_pend;
            tx_valid  <= mem_valid;
            if (mem_valid) begin
                dout <= rdata;
            end
            if (rd_cmd) begin
                rd_addr <= raddr;
            end
            if (rx_valid) begin
                case (cmd)
                    SET_WADDR: waddr <= set_addr;
                    SET_RADDR: raddr <= set_addr;
`ifdef SPI_RAM_AUTOINC_EN
                    WRITE: begin
                        waddr     <= (waddr == LAST_ADDR) ? '0 : waddr + ADDR_SIZE'(1);
                        addr_wrap <= (waddr == LAST_ADDR);
                    end
                    READ: begin
                        raddr     <= (raddr == LAST_ADDR) ? '0 : raddr + ADDR_SIZE'(1);
                        addr_wrap <= (raddr == LAST_ADDR);
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // Status FSM tracking the read pipeline occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (rd_cmd) state <= RD_MEM;
                RD_MEM:  state <= RD_OUT;
                RD_OUT:  state <= rd_cmd ? RD_MEM : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Self-checking bench for spi_ram_burst: a command-level memory model schedules expected
// outputs per clock edge; a compare process checks them every cycle, plus literal spot checks.
module tb_spi_ram_burst;

    localparam int W = 8;
    localparam int A = 8;
    localparam int D = 256;
    localparam int HORIZON = 4096;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W+1:0] din = '0;
    logic         rx_valid = 1'b0;
    logic [W-1:0] dout;
    logic         tx_valid;
    logic         addr_wrap;

    spi_ram_burst #(
        .MEM_WIDTH(W),
        .ADDR_SIZE(A),
        .MEM_DEPTH(D)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid),
        .addr_wrap(addr_wrap)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;
    bit check_en = 1'b0;

    // Model: memory contents, pointers, and per-edge expected outputs.
    logic [W-1:0] mem_m [D];
    int           waddr_m = 0;
    int           raddr_m = 0;
    bit           exp_tx   [HORIZON];
    logic [W-1:0] exp_data [HORIZON];
    bit           exp_wrap [HORIZON];
    logic [W-1:0] dout_m = '0;

    task automatic check_output(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, actual, expected, edge_cnt);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && check_en && edge_cnt < HORIZON) begin
            if (exp_tx[edge_cnt]) dout_m = exp_data[edge_cnt];
            check_output("tx_valid", {31'b0, tx_valid}, {31'b0, exp_tx[edge_cnt]});
            check_output("addr_wrap", {31'b0, addr_wrap}, {31'b0, exp_wrap[edge_cnt]});
            check_output("dout", {24'b0, dout}, {24'b0, dout_m});
        end
    end

    // Drive one command for the next edge and advance the model by one command.
    task automatic apply_stimulus(bit v, logic [1:0] cmd, logic [W-1:0] payload);
        int e;
        e = edge_cnt + 1;
        rx_valid = v;
        din = {cmd, payload};
        if (v && e + 2 < HORIZON) begin
            case (cmd)
                2'b00: waddr_m = int'(payload) % D;
                2'b01: begin
                    mem_m[waddr_m] = payload;
`ifdef SPI_RAM_AUTOINC_EN
                    if (waddr_m == D - 1) begin
                        waddr_m = 0;
                        exp_wrap[e] = 1'b1;
                    end else begin
                        waddr_m++;
                    end
`endif
                end
                2'b10: raddr_m = int'(payload) % D;
                default: begin
                    exp_tx[e + 2] = 1'b1;
                    exp_data[e + 2] = mem_m[raddr_m];
`ifdef SPI_RAM_AUTOINC_EN
                    if (raddr_m == D - 1) begin
                        raddr_m = 0;
                        exp_wrap[e] = 1'b1;
                    end else begin
                        raddr_m++;
                    end
`endif
                end
            endcase
        end
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 2'b00, 8'h00);
    endtask

    task automatic apply_reset();
        rx_valid = 1'b0;
        din = '0;
        rst_n = 1'b0;
        for (int i = edge_cnt + 1; i < HORIZON; i++) begin
            exp_tx[i] = 1'b0;
            exp_wrap[i] = 1'b0;
        end
        waddr_m = 0;
        raddr_m = 0;
        dout_m = '0;
        #1;
        check_output("reset tx_valid", {31'b0, tx_valid}, 32'h0);
        check_output("reset addr_wrap", {31'b0, addr_wrap}, 32'h0);
        check_output("reset dout", {24'b0, dout}, 32'h0);
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        apply_reset();
        check_en = 1'b1;

        // Known background pattern so every read has a defined result.
        for (int a = 0; a < D; a++) begin
            apply_stimulus(1'b1, 2'b00, 8'(a));
            apply_stimulus(1'b1, 2'b01, 8'(a) ^ 8'h5A);
        end

        // Single write/read, latency exactly two edges.
        apply_stimulus(1'b1, 2'b00, 8'h05);
        apply_stimulus(1'b1, 2'b01, 8'hAB);
        apply_stimulus(1'b1, 2'b10, 8'h05);
        apply_stimulus(1'b1, 2'b11, 8'h00);
        idle(1);
        check_output("lat1 tx_valid", {31'b0, tx_valid}, 32'h0);
        idle(1);
        check_output("lat2 tx_valid", {31'b0, tx_valid}, 32'h1);
        check_output("lat2 dout", {24'b0, dout}, 32'hAB);
        idle(1);
        check_output("hold dout", {24'b0, dout}, 32'hAB);

        // Burst write then back-to-back reads.
        apply_stimulus(1'b1, 2'b00, 8'h10);
        apply_stimulus(1'b1, 2'b01, 8'h11);
        apply_stimulus(1'b1, 2'b01, 8'h22);
        apply_stimulus(1'b1, 2'b01, 8'h33);
        apply_stimulus(1'b1, 2'b10, 8'h10);
        apply_stimulus(1'b1, 2'b11, 8'h00);
        apply_stimulus(1'b1, 2'b11, 8'h00);
        apply_stimulus(1'b1, 2'b11, 8'h00);
`ifdef SPI_RAM_AUTOINC_EN
        check_output("burst0", {24'b0, dout}, 32'h11);
        idle(1);
        check_output("burst1", {24'b0, dout}, 32'h22);
        idle(1);
        check_output("burst2", {24'b0, dout}, 32'h33);
`else
        check_output("burst0", {24'b0, dout}, 32'h33);
        idle(1);
        check_output("burst1", {24'b0, dout}, 32'h33);
        idle(1);
        check_output("burst2", {24'b0, dout}, 32'h33);
`endif
        idle(1);

        // Reset with a read in flight: it must never appear.
        apply_stimulus(1'b1, 2'b11, 8'h00);
        apply_reset();
        idle(3);
        apply_stimulus(1'b1, 2'b11, 8'h00);
        apply_stimulus(1'b1, 2'b01, 8'h77);
        apply_stimulus(1'b1, 2'b10, 8'h00);
        check_output("post-reset read old", {24'b0, dout}, 32'h5A);
        check_output("post-reset tx_valid", {31'b0, tx_valid}, 32'h1);
        apply_stimulus(1'b1, 2'b11, 8'h00);
        idle(2);
        check_output("post-reset read new", {24'b0, dout}, 32'h77);

        // Pointer wrap at the top of memory.
        apply_stimulus(1'b1, 2'b00, 8'hFF);
        apply_stimulus(1'b1, 2'b01, 8'hAA);
`ifdef SPI_RAM_AUTOINC_EN
        check_output("wrap pulse", {31'b0, addr_wrap}, 32'h1);
`else
        check_output("wrap pulse", {31'b0, addr_wrap}, 32'h0);
`endif
        apply_stimulus(1'b1, 2'b01, 8'hBB);
        check_output("wrap single", {31'b0, addr_wrap}, 32'h0);
        apply_stimulus(1'b1, 2'b10, 8'hFF);
        apply_stimulus(1'b1, 2'b11, 8'h00);
        apply_stimulus(1'b1, 2'b10, 8'h00);
        apply_stimulus(1'b1, 2'b11, 8'h00);
`ifdef SPI_RAM_AUTOINC_EN
        check_output("wrap read FF", {24'b0, dout}, 32'hAA);
        idle(2);
        check_output("wrap read 00", {24'b0, dout}, 32'hBB);
`else
        check_output("wrap read FF", {24'b0, dout}, 32'hBB);
        idle(2);
        check_output("wrap read 00", {24'b0, dout}, 32'h77);
`endif

        // Write to the address of an in-flight read returns old data.
        apply_stimulus(1'b1, 2'b10, 8'h40);
        apply_stimulus(1'b1, 2'b00, 8'h40);
        apply_stimulus(1'b1, 2'b11, 8'h00);
        apply_stimulus(1'b1, 2'b01, 8'h99);
        idle(1);
        check_output("raw old data", {24'b0, dout}, 32'h1A);
        apply_stimulus(1'b1, 2'b10, 8'h40);
        apply_stimulus(1'b1, 2'b11, 8'h00);
        idle(2);
        check_output("raw new data", {24'b0, dout}, 32'h99);

        // Repeated writes at 0x20; 0x21 keeps its pattern unless pointers auto-increment.
        apply_stimulus(1'b1, 2'b00, 8'h20);
        apply_stimulus(1'b1, 2'b01, 8'h01);
        apply_stimulus(1'b1, 2'b01, 8'h02);
        apply_stimulus(1'b1, 2'b10, 8'h20);
        apply_stimulus(1'b1, 2'b11, 8'h00);
        apply_stimulus(1'b1, 2'b10, 8'h21);
        apply_stimulus(1'b1, 2'b11, 8'h00);
`ifdef SPI_RAM_AUTOINC_EN
        check_output("mem20", {24'b0, dout}, 32'h01);
        idle(2);
        check_output("mem21", {24'b0, dout}, 32'h02);
`else
        check_output("mem20", {24'b0, dout}, 32'h02);
        idle(2);
        check_output("mem21", {24'b0, dout}, 32'h7B);
`endif

        // Idle bus with busy din: nothing may change.
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b0, 2'(i), 8'($urandom));
        end
        apply_stimulus(1'b1, 2'b11, 8'h00);
        idle(2);
`ifdef SPI_RAM_AUTOINC_EN
        check_output("idle then read", {24'b0, dout}, 32'h78);
`else
        check_output("idle then read", {24'b0, dout}, 32'h7B);
`endif
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_ram_burst.md
SPI_RAM_BURST -- requirements
Module: spi_ram_burst

Interface
REQ-001 SHALL have parameter MEM_WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter ADDR_SIZE, default 8: address width in bits.
REQ-003 SHALL have parameter MEM_DEPTH, default 256: number of words; legal range 2 .. 2**ADDR_SIZE.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port din, input, MEM_WIDTH+2: bits [MEM_WIDTH+1:MEM_WIDTH] are the command; the remaining bits are the payload.
REQ-007 SHALL have port rx_valid, input, 1: din is valid this cycle.
REQ-008 SHALL have port dout, output, MEM_WIDTH: read data.
REQ-009 SHALL have port tx_valid, output, 1: dout is valid (one-cycle pulse).
REQ-010 SHALL have port addr_wrap, output, 1: one-cycle pulse when either address pointer wraps.

Function
REQ-011 SHALL act only on cycles with rx_valid=1; with rx_valid=0, internal state and dout hold, and tx_valid and addr_wrap are 0.
REQ-012 SHALL decode cmd 00 (SET_WADDR): waddr <= payload[ADDR_SIZE-1:0].
REQ-013 SHALL decode cmd 01 (WRITE): mem[waddr] <= payload, then waddr increments.
REQ-014 SHALL decode cmd 10 (SET_RADDR): raddr <= payload[ADDR_SIZE-1:0].
REQ-015 SHALL decode cmd 11 (READ): read mem[raddr], then raddr increments; payload is ignored.
REQ-016 SHALL deliver READ data with 2-cycle latency: READ accepted at edge N gives dout and tx_valid=1 after edge N+2 (synchronous RAM read plus output register).
REQ-017 SHALL handle back-to-back READs fully pipelined, one word per cycle, so consecutive reads return consecutive addresses in order.
REQ-018 SHALL wrap an incremented pointer equal to MEM_DEPTH-1 to 0 and pulse addr_wrap in the same cycle the pointer updates.
REQ-019 SHALL take a SET_RADDR/SET_WADDR payload >= MEM_DEPTH modulo MEM_DEPTH.
REQ-020 SHALL, when WRITE and an in-flight READ target the same address, return the pre-write (old) data for that READ.
REQ-021 SHALL keep dout holding its last value when tx_valid=0.
REQ-022 SHALL keep the read pipeline state machine with states IDLE, RD_MEM and RD_OUT: IDLE->RD_MEM on READ; RD_MEM->RD_OUT always; RD_OUT->RD_MEM on a new READ, else IDLE.

Reset
REQ-023 SHALL, on rst_n=0, asynchronously set dout=0, tx_valid=0, addr_wrap=0, waddr=0, raddr=0 and state=IDLE.
REQ-024 SHALL leave memory contents unchanged by reset.
REQ-025 SHALL discard any reads in flight when reset is applied mid-operation; no tx_valid pulse follows reset release.

Configuration
REQ-026 SHALL, when SPI_RAM_AUTOINC_EN is defined, increment pointers as in REQ-013/015/018.
REQ-027 SHALL, when SPI_RAM_AUTOINC_EN is undefined, leave pointers unchanged after WRITE/READ and hold addr_wrap at constant 0.

Structure
REQ-028 SHALL place the command encoding typedef (SET_WADDR, WRITE, SET_RADDR, READ) and the FSM state typedef in the shared package spi_ram_pkg.
REQ-029 SHALL instantiate the storage as sub-module spi_ram_mem: single write port, single synchronous read port, parameterised by MEM_WIDTH, ADDR_SIZE and MEM_DEPTH.

Verification
REQ-030 SHALL cover: 0x005 then 0x1AB, then 0x205 then 0x300 -> dout=0xAB with tx_valid=1 exactly 2 cycles after READ.
REQ-031 SHALL cover: SET_WADDR 0x10, WRITE 0x11/0x22/0x33, SET_RADDR 0x10, three back-to-back READs -> 0x11, 0x22, 0x33 on consecutive cycles.
REQ-032 SHALL cover: SET_WADDR 0xFF, WRITE 0xAA, WRITE 0xBB -> addr_wrap pulses once; then reading at 0xFF and 0x00 returns 0xAA and 0xBB.
REQ-033 SHALL cover: rst_n low for one cycle between a READ and its data -> no tx_valid; dout=0; waddr=raddr=0.
REQ-034 SHALL cover: SPI_RAM_AUTOINC_EN undefined, WRITE 0x01 then 0x02 at addr 0x20 -> mem[0x20]=0x02, mem[0x21] unchanged.
REQ-035 SHALL cover: rx_valid=0 with toggling din for 10 cycles -> no state change and no pulses.
